// File: rtl/ann_coef_loader.sv
// Coefficient loader for the ANN core: fills the image and first-layer weight buffers from a
// 16-bit valid/ready word stream. Optional trailer checksum: define ANN_COEF_CHECKSUM_EN.
module ann_coef_loader #(
    parameter int IMAGE_SIZE  = 64,
    parameter int FIRST_LAYER = 16
) (
    input  logic                                          clk,
    input  logic                                          n_rst,
    input  logic                                          request_coef,
    input  logic [1:0]                                    coef_select,
    input  logic [15:0]                                   stream_data,
    input  logic                                          stream_valid,
    output logic                                          stream_ready,
    output logic [IMAGE_SIZE-1:0][15:0]                   image_o,
    output logic [FIRST_LAYER-1:0][IMAGE_SIZE-1:0][15:0]  weights_o,
    output logic                                          busy,
    output logic                                          load_done,
    output logic                                          coef_valid,
    output logic                                          coef_error,
    output logic [2:0]                                    dbg_state
);

    // Stream handshake: a word moves on a rising edge where stream_valid && stream_ready.
    // stream_ready is high exactly in LOAD_IMG, LOAD_WGT and CHECK; the producer may hold
    // stream_valid high at any time, words offered while stream_ready is low are not taken.

    localparam int PW = (IMAGE_SIZE  > 1) ? $clog2(IMAGE_SIZE)  : 1;
    localparam int NW = (FIRST_LAYER > 1) ? $clog2(FIRST_LAYER) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(IMAGE_SIZE - 1);
    localparam logic [NW-1:0] NEU_LAST = NW'(FIRST_LAYER - 1);

`ifdef ANN_COEF_CHECKSUM_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // CHECK keeps its encoding in every build so dbg_state decodes the same way.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_IMG = 3'd1,
        LOAD_WGT = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] pix_cnt;
    logic [NW-1:0] neu_cnt;
    logic          wgt_after_img;
    logic [15:0]   sum;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            neu_cnt       <= '0;
            wgt_after_img <= 1'b0;
            sum           <= '0;
            stream_ready  <= 1'b0;
            busy          <= 1'b0;
            load_done     <= 1'b0;
            coef_valid    <= 1'b0;
            coef_error    <= 1'b0;
            image_o       <= '0;
            weights_o     <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (request_coef) begin
                        coef_valid    <= 1'b0;
                        coef_error    <= 1'b0;
                        pix_cnt       <= '0;
                        neu_cnt       <= '0;
                        sum           <= '0;
                        wgt_after_img <= (coef_select == 2'b10);
                        case (coef_select)
                            2'b00, 2'b10: begin
                                state        <= LOAD_IMG;
                                busy         <= 1'b1;
                                stream_ready <= 1'b1;
                            end
                            2'b01: begin
                                state        <= LOAD_WGT;
                                busy         <= 1'b1;
                                stream_ready <= 1'b1;
                            end
                            default: coef_error <= 1'b1;
                        endcase
                    end
                end

                LOAD_IMG: begin
                    if (stream_valid) begin
                        image_o[pix_cnt] <= stream_data;
                        sum              <= sum + stream_data;
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt <= '0;
                            if (wgt_after_img) begin
                                state <= LOAD_WGT;
                            end else if (CHECK_EN) begin
                                state <= CHECK;
                            end else begin
                                state        <= DONE;
                                busy         <= 1'b0;
                                stream_ready <= 1'b0;
                                load_done    <= 1'b1;
                                coef_valid   <= 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + PW'(1);
                        end
                    end
                end

                LOAD_WGT: begin
                    if (stream_valid) begin
                        weights_o[neu_cnt][pix_cnt] <= stream_data;
                        sum                         <= sum + stream_data;
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt <= '0;
                            if (neu_cnt == NEU_LAST) begin
                                neu_cnt <= '0;
                                if (CHECK_EN) begin
                                    state <= CHECK;
                                end else begin
                                    state        <= DONE;
                                    busy         <= 1'b0;
                                    stream_ready <= 1'b0;
                                    load_done    <= 1'b1;
                                    coef_valid   <= 1'b1;
                                end
                            end else begin
                                neu_cnt <= neu_cnt + NW'(1);
                            end
                        end else begin
                            pix_cnt <= pix_cnt + PW'(1);
                        end
                    end
                end

                CHECK: begin
                    // The trailer word is consumed but never stored in a buffer.
                    if (stream_valid) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        stream_ready <= 1'b0;
                        load_done    <= 1'b1;
                        if (stream_data == sum) coef_valid <= 1'b1;
                        else                    coef_error <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    stream_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ann_coef_loader.sv
// Randomized bench for ann_coef_loader: a word-index model of the load sequence is compared
// against the DUT every cycle, plus literal spot checks. Honours ANN_COEF_CHECKSUM_EN.
module tb_ann_coef_loader;

    localparam int IS = 64;
    localparam int FL = 16;
`ifdef ANN_COEF_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          n_rst;
    logic                          request_coef;
    logic [1:0]                    coef_select;
    logic [15:0]                   stream_data;
    logic                          stream_valid;
    logic                          stream_ready;
    logic [IS-1:0][15:0]           image_o;
    logic [FL-1:0][IS-1:0][15:0]   weights_o;
    logic                          busy;
    logic                          load_done;
    logic                          coef_valid;
    logic                          coef_error;
    logic [2:0]                    dbg_state;

    ann_coef_loader #(.IMAGE_SIZE(IS), .FIRST_LAYER(FL)) dut (
        .clk(clk), .n_rst(n_rst), .request_coef(request_coef), .coef_select(coef_select),
        .stream_data(stream_data), .stream_valid(stream_valid), .stream_ready(stream_ready),
        .image_o(image_o), .weights_o(weights_o), .busy(busy), .load_done(load_done),
        .coef_valid(coef_valid), .coef_error(coef_error), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a load is a sequence of m_total words, word k lands by plain arithmetic.
    logic [15:0] img_m [IS];
    logic [15:0] wgt_m [FL][IS];
    bit          m_loading, m_done, m_valid, m_error, m_has_img;
    int          m_total, m_got;
    logic [15:0] m_sum;
    bit          chk_en = 1'b0;
    int          valid_rises;
    bit          prev_cv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < IS; i++) img_m[i] = '0;
        for (int n = 0; n < FL; n++)
            for (int p = 0; p < IS; p++) wgt_m[n][p] = '0;
        m_loading = 0; m_done = 0; m_valid = 0; m_error = 0;
        m_has_img = 0; m_total = 0; m_got = 0; m_sum = '0;
    endtask

    task automatic model_store(input int k, input logic [15:0] d);
        int j;
        if (m_has_img && k < IS) begin
            img_m[k] = d;
        end else begin
            j = k - (m_has_img ? IS : 0);
            wgt_m[j / IS][j % IS] = d;
        end
    endtask

    task automatic model_edge(input bit req, input logic [1:0] sel, input bit vld,
                              input logic [15:0] d);
        if (m_done) begin
            m_done = 0;
        end else if (!m_loading) begin
            if (req) begin
                m_valid = 0;
                m_error = 0;
                if (sel == 2'b11) begin
                    m_error = 1;
                end else begin
                    m_loading = 1;
                    m_has_img = (sel != 2'b01);
                    m_total   = (sel == 2'b00) ? IS : (sel == 2'b01) ? IS * FL : IS * (FL + 1);
                    m_got     = 0;
                    m_sum     = '0;
                end
            end
        end else if (vld) begin
            if (m_got < m_total) begin
                model_store(m_got, d);
                m_sum = m_sum + d;
                m_got++;
                if (m_got == m_total && !CK) begin
                    m_loading = 0; m_done = 1; m_valid = 1;
                end
            end else begin
                m_loading = 0;
                m_done    = 1;
                if (d == m_sum) m_valid = 1;
                else            m_error = 1;
            end
        end
    endtask

    task automatic step(input bit req, input logic [1:0] sel, input bit vld, input logic [15:0] d);
        request_coef = req;
        coef_select  = sel;
        stream_valid = vld;
        stream_data  = d;
        @(posedge clk);
        model_edge(req, sel, vld, d);
        #1;
    endtask

    // Issues a request and streams until the model says the load is over, then spends the
    // DONE cycle (optionally with a request that must be ignored there).
    task automatic run_load(input logic [1:0] sel, input int gap_pct, input int mode,
                            input logic [15:0] base, input logic [15:0] corrupt,
                            input int pulse_at, input bit req_in_done);
        bit          vld;
        bit          pulse;
        bit          pulsed;
        logic [15:0] d;
        pulsed = 0;
        step(1'b1, sel, 1'b0, 16'h0000);
        while (m_loading) begin
            vld = ($urandom_range(0, 99) >= gap_pct);
            if (m_got >= m_total) begin
                d = m_sum ^ corrupt;
            end else begin
                case (mode)
                    0:       d = base + 16'(m_got);
                    1:       d = 16'(m_got) ^ 16'h5A5A;
                    2:       d = 16'($urandom);
                    default: d = base;
                endcase
            end
            pulse = (!pulsed && m_got == pulse_at);
            if (pulse) pulsed = 1;
            step(pulse, pulse ? 2'b11 : sel, vld, d);
        end
        step(req_in_done, 2'b11, 1'b1, 16'hFFFF);
    endtask

    always @(negedge clk) begin : compare
        int bad;
        if (chk_en) begin
            check("stream_ready", stream_ready, m_loading);
            check("busy", busy, m_loading);
            check("load_done", load_done, m_done);
            check("coef_valid", coef_valid, m_valid);
            check("coef_error", coef_error, m_error);
            bad = -1;
            for (int i = 0; i < IS; i++)
                if (bad < 0 && image_o[i] !== img_m[i]) bad = i;
            if (bad < 0) bad = 0;
            check($sformatf("image_o[%0d]", bad), image_o[bad], img_m[bad]);
            bad = -1;
            for (int n = 0; n < FL; n++)
                for (int p = 0; p < IS; p++)
                    if (bad < 0 && weights_o[n][p] !== wgt_m[n][p]) bad = n * IS + p;
            if (bad < 0) bad = 0;
            check($sformatf("weights_o[%0d][%0d]", bad / IS, bad % IS),
                  weights_o[bad / IS][bad % IS], wgt_m[bad / IS][bad % IS]);
            if (coef_valid && !prev_cv) valid_rises++;
            prev_cv = coef_valid;
        end
    end

    initial begin
        n_rst        = 1'b0;
        request_coef = 1'b0;
        coef_select  = 2'b00;
        stream_data  = 16'h0000;
        stream_valid = 1'b0;
        prev_cv      = 1'b0;
        valid_rises  = 0;
        model_reset();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", stream_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", load_done, 0);
        check("rst_valid", coef_valid, 0);
        check("rst_error", coef_error, 0);
        check("rst_image_zero", 32'(|image_o), 0);
        check("rst_weights_zero", 32'(|weights_o), 0);
        n_rst  = 1'b1;
        chk_en = 1'b1;

        // Idle: offered words must not be consumed.
        for (int i = 0; i < 6; i++) step(1'b0, 2'($urandom_range(0, 3)), 1'b1, 16'($urandom));

        // Image load, continuous valid, words 0x0100+k.
        step(1'b1, 2'b00, 1'b0, 16'h0000);
        for (int k = 0; k < IS; k++) step(1'b0, 2'b00, 1'b1, 16'h0100 + 16'(k));
        if (CK) step(1'b0, 2'b00, 1'b1, m_sum);
        // DONE occupies the cycle that starts at the 64th edge after the request edge.
        check("img_latency_done", load_done, 1);
        check("img_coef_valid", coef_valid, 1);
        check("img_word5", image_o[5], 16'h0105);
        check("img_word63", image_o[63], 16'h013F);
        step(1'b0, 2'b00, 1'b1, 16'h1234);
        check("img_done_one_cycle", load_done, 0);

        // Weights load with random valid gaps.
        run_load(2'b01, 30, 1, 16'h0000, 16'h0000, -1, 1'b0);
        check("wgt_3_5", weights_o[3][5], 16'h5A9F);
        check("wgt_15_63", weights_o[15][63], 16'h59A5);
        check("wgt_0_0", weights_o[0][0], 16'h5A5A);
        check("wgt_image_kept", image_o[5], 16'h0105);
        check("wgt_coef_valid", coef_valid, 1);

        // Image then weights, with a stray request mid-load and one in the DONE cycle.
        valid_rises = 0;
        run_load(2'b10, 20, 0, 16'h2000, 16'h0000, 500, 1'b1);
        check("both_img63", image_o[63], 16'h203F);
        check("both_wgt00", weights_o[0][0], 16'h2040);
        check("both_wgt15_63", weights_o[15][63], 16'h243F);
        check("both_valid_rises", valid_rises, 1);
        check("both_no_error", coef_error, 0);

        // Reserved select.
        step(1'b1, 2'b11, 1'b1, 16'hBEEF);
        check("sel11_error", coef_error, 1);
        check("sel11_valid", coef_valid, 0);
        check("sel11_busy", busy, 0);
        check("sel11_ready", stream_ready, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'b00, 1'b1, 16'($urandom));
        run_load(2'b00, 40, 2, 16'h0000, 16'h0000, -1, 1'b0);
        check("sel00_clears_error", coef_error, 0);
        check("sel00_valid", coef_valid, 1);

        // Reset in the middle of a weight load after 300 words.
        step(1'b1, 2'b01, 1'b0, 16'h0000);
        for (int i = 0; i < 300; i++) step(1'b0, 2'b01, 1'b1, 16'($urandom));
        #1;
        n_rst = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", stream_ready, 0);
        check("midrst_valid", coef_valid, 0);
        check("midrst_image_zero", 32'(|image_o), 0);
        check("midrst_weights_zero", 32'(|weights_o), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        run_load(2'b00, 25, 2, 16'h0000, 16'h0000, -1, 1'b0);
        run_load(2'b01, 10, 2, 16'h0000, 16'h0000, -1, 1'b0);

        if (CK) begin
            // Image of all ones: trailer 0x0040 is right, 0x0041 is wrong.
            run_load(2'b00, 0, 3, 16'h0001, 16'h0000, -1, 1'b0);
            check("ck_sum_ok_valid", coef_valid, 1);
            check("ck_sum_ok_error", coef_error, 0);
            run_load(2'b00, 15, 3, 16'h0001, 16'h0001, -1, 1'b0);
            check("ck_sum_bad_error", coef_error, 1);
            check("ck_sum_bad_valid", coef_valid, 0);
        end

        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b0, 16'h0000);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ann_coef_loader.md
# ann_coef_loader

Upstream feeder for the ANN core. Accepts a 16-bit word stream from the verification/host side with a valid/ready handshake and fills the image buffer and the first-layer weight buffer the ANN reads. It then raises a level flag that drives the ANN's `image_weights_loaded` input. Loads are started by the ANN's `request_coef`/`coef_select` pair.

## Interface
- `IMAGE_SIZE`, 64: pixels per image, i.e. words per weight row.
- `FIRST_LAYER`, 16: first-layer neurons, i.e. weight rows.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `request_coef`  in  1  load request; sampled only in IDLE.
- `coef_select`  in  2  load type, sampled with `request_coef`: 00 image, 01 weights, 10 image then weights, 11 reserved.
- `stream_data`  in  16  incoming word.
- `stream_valid`  in  1  `stream_data` is valid.
- `stream_ready`  out  1  loader accepts a word this cycle.
- `image_o`  out  16 x IMAGE_SIZE  image buffer.
- `weights_o`  out  16 x FIRST_LAYER x IMAGE_SIZE  weight buffer, indexed [neuron][pixel].
- `busy`  out  1  a load is in progress.
- `load_done`  out  1  one-cycle pulse when a load completes.
- `coef_valid`  out  1  level, feeds ANN `image_weights_loaded`.
- `coef_error`  out  1  sticky error flag.

## Operation
- States: IDLE, LOAD_IMG, LOAD_WGT, CHECK (only with the macro), DONE.
- IDLE, `request_coef`=1:
  - Clears `coef_valid`, `coef_error` and all counters.
  - `coef_select` 00 or 10 → LOAD_IMG; 01 → LOAD_WGT.
  - `coef_select` 11 → stays IDLE, sets `coef_error`, `coef_valid` stays 0.
- `request_coef` outside IDLE is ignored. There is no abort.
- A word transfers when `stream_valid` && `stream_ready`. `stream_ready` = 1 in LOAD_IMG, LOAD_WGT and CHECK, 0 otherwise.
- LOAD_IMG:
  - Word k goes to `image_o[k]`, k = 0..IMAGE_SIZE-1, via a pixel counter.
  - On transfer of word IMAGE_SIZE-1: go to LOAD_WGT if `coef_select` was 10, otherwise to DONE (or CHECK when enabled).
- LOAD_WGT:
  - Row-major order: word (n·IMAGE_SIZE + p) goes to `weights_o[n][p]`.
  - The pixel counter wraps at IMAGE_SIZE-1 and the neuron counter then increments.
  - After word FIRST_LAYER·IMAGE_SIZE-1: go to DONE (or CHECK).
- DONE:
  - Lasts one cycle: `load_done`=1, `coef_valid` set, `busy`=0, then IDLE.
  - `coef_valid` holds until the next accepted request or reset.
- Buffer entries not written by a load keep their prior contents.
- `stream_valid`=0 stalls counters and state indefinitely. Words presented while `stream_ready`=0 are not consumed.
- Reset: every output is 0, all buffer entries are 0, state is IDLE, counters are 0.
- Reset asserted mid-load: the partial load is discarded, buffers are zeroed, and `coef_valid` stays 0.

## Timing
- Request seen at edge t → `busy`=1 and `stream_ready`=1 from t+1.
- A word transferred at edge t is visible on `image_o`/`weights_o` after t.
- Last word at edge t → DONE in cycle t+1 (`load_done`=1, `coef_valid`=1) → IDLE at t+2.
- With the macro, CHECK is inserted between the last word and DONE.
- Minimum request-to-done time with `stream_valid` held at 1: N+1 cycles for N words. N = 64 (image), 1024 (weights), 1088 (both) at default parameters.
- A new request is accepted at the earliest in the cycle after DONE.
- `busy` = (state ≠ IDLE && state ≠ DONE).

## Configuration
- `ANN_COEF_CHECKSUM_EN`:
  - Defined: a 16-bit running sum (mod 2^16) covers every accepted data word of the load sequence. In CHECK, one extra word is transferred and compared to the sum.
    - Match → DONE.
    - Mismatch → `coef_error`=1, `coef_valid` stays 0, `load_done` still pulses, then IDLE.
  - Undefined: no CHECK state, no trailer word, `coef_error` is set only by select 11.

## Test plan
- Reset mid-LOAD_WGT after 300 words → all buffers 0, `coef_valid`=0, `busy`=0, `stream_ready`=0 immediately.
- Select 00, stream words 0x0100+k with continuous valid → `image_o[k]`=0x0100+k; `load_done` 65 cycles after the request edge; `coef_valid`=1.
- Select 01, random gaps in `stream_valid` → `weights_o[3][5]` equals word 197; `weights_o[15][63]` equals word 1023; counters wrap correctly; nothing is written during gaps.
- Select 10 → image gets words 0–63 and `weights_o[0][0]` gets word 64; a `request_coef` pulse mid-load is ignored; `coef_valid` rises once.
- Select 11 → `coef_error`=1, `busy` never rises, `stream_ready`=0; a following select-00 request clears `coef_error`.
- With `ANN_COEF_CHECKSUM_EN`: image of all 0x0001 with trailer 0x0040 → `coef_valid`=1. Trailer 0x0041 → `coef_error`=1, `coef_valid`=0.
